pci_target: RTL

- PCI-style bus target that pairs with the initiator controller on the same shared bus: frame, irdy, AD, C_BE, plus the target-side signals devsel, trdy and stop.
- Decodes the address phase against its device ID, then claims the transaction with devsel.
- Serves single and burst reads and writes from an internal word memory.
- Disconnects bursts that exceed a fixed length, then releases the bus with a one-cycle turnaround.

---
 rtl/pci_target.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pci_target.sv
// PCI-style bus target: claims frames addressed to DEV_ID, serves single and
// burst reads/writes from a small word memory and disconnects long bursts.
module pci_target #(
    parameter logic [1:0] DEV_ID      = 2'd1,
    parameter int         DEPTH       = 8,
    parameter int         WAIT_STATES = 1,
    parameter int         MAX_BURST   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        irdy,
    input  logic [3:0]  C_BE,
    inout  logic [31:0] AD,
    output logic        devsel,
    output logic        trdy,
    output logic        stop,
    output logic        busy
);
    // state | meaning
    // IDLE  | bus released, waiting for an address phase
    // SKIP  | frame not ours, wait for bus idle
    // WAIT  | devsel asserted, target wait states (read turnaround)
    // DATA  | trdy asserted, data phases
    // STOPW | burst limit hit, holding stop until frame rises
    // TURN  | one cycle driving controls high before release

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SKIP, WAIT, DATA, STOPW, TURN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic [3:0]    beat_cnt;
    logic [2:0]    wait_cnt;
    logic          rd;
    logic [31:0]   mem [DEPTH];

    logic hit, last_beat, xfer;
    logic ctl_drive, ad_drive, devsel_val, trdy_val, stop_val;

    // Only write (0) and read (1) are claimed, so the upper command bits must be 0.
    assign hit       = (AD[1:0] == DEV_ID) && (C_BE[3:1] == 3'b000);
    assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));
    assign xfer      = (state == DATA) && !irdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            rd       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && !frame && hit) begin
                idx      <= AD[AW+1:2];
                rd       <= C_BE[0];
                wait_cnt <= 3'(WAIT_STATES);
                beat_cnt <= '0;
            end
            if (state == WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
            if (xfer) begin
                if (!rd) begin
                    for (int b = 0; b < 4; b++)
                        if (!C_BE[b]) mem[idx][8*b +: 8] <= AD[8*b +: 8];
                end
                idx      <= idx + AW'(1);
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!frame) state_nxt = hit ? WAIT : SKIP;
            SKIP:  if (frame && irdy) state_nxt = IDLE;
            WAIT:  if (wait_cnt == 3'd0) state_nxt = DATA;
            DATA: begin
                // A final phase wins over the burst limit on the same edge.
                if (!irdy) begin
                    if (frame)          state_nxt = TURN;
                    else if (last_beat) state_nxt = STOPW;
                end
            end
            STOPW: if (frame) state_nxt = TURN;
            TURN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ctl_drive  = 1'b1;
        devsel_val = 1'b1;
        trdy_val   = 1'b1;
        stop_val   = 1'b1;
        ad_drive   = 1'b0;
        case (state)
            IDLE, SKIP: ctl_drive = 1'b0;
            WAIT:       devsel_val = 1'b0;
            DATA: begin
                devsel_val = 1'b0;
                trdy_val   = 1'b0;
                stop_val   = !last_beat;
                ad_drive   = rd;
            end
            STOPW: begin
                devsel_val = 1'b0;
                stop_val   = 1'b0;
            end
            default: ;
        endcase
    end

    assign devsel = ctl_drive ? devsel_val : 1'bz;
    assign trdy   = ctl_drive ? trdy_val   : 1'bz;
    assign stop   = ctl_drive ? stop_val   : 1'bz;
    assign AD     = ad_drive  ? mem[idx]   : 32'bz;
    assign busy   = (state != IDLE);

endmodule
